// File: rtl/hi_lo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Also holds the iteration count and the divide-by-zero LO fill value.
package hi_lo_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MADD  = 3'd5,
        OP_MADDU = 3'd6,
        OP_MSUB  = 3'd7
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINISH
    } hilo_state_e;

    // Default operand width; the iteration count equals the operand width.
    localparam int unsigned ITER = 32;

    // LO result of a divide by zero; sliced to the operand width (max 64).
    localparam logic [63:0] DIV0_LO = '1;

    function automatic logic is_signed_op(input hilo_op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_div_op(input hilo_op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/hi_lo_iter_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: shift-add; divide: restoring shift-compare-subtract.
module hi_lo_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, m_i};
        if (is_div_i) begin
            // Borrow out means the divisor did not fit: keep the shifted remainder.
            hi_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hi_lo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// FSM IDLE -> CALC (WIDTH iterations) -> FINISH (sign fixup, commit).
module hi_lo_unit
    import hi_lo_pkg::*;
#(
    parameter int unsigned WIDTH = ITER
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       HiLoOp,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             MoveToHi,
    input  logic             MoveToLo,
    input  logic             ReadHiLo,
    output logic [WIDTH-1:0] ReadDataHi,
    output logic [WIDTH-1:0] ReadDataLo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    hilo_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] m_q, m_d, a_q, a_d;
    hilo_op_e         op_q, op_d;
    logic             is_div_q, is_div_d, div0_q, div0_d;
    logic             neg_res_q, neg_res_d, neg_a_q, neg_a_d;
    logic             done_q, done_d;

    hilo_op_e         op_in;
    logic             launch;
    logic             sgn_in, neg_a_in, neg_b_in, div_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic [WIDTH-1:0] quot, rem;
    logic [2*WIDTH-1:0] prod_mag, prod_s, mul_res;

    assign op_in  = hilo_op_e'(HiLoOp);
    assign launch = Start && (op_in != OP_NOP);

    hi_lo_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (launch) state_d = ST_CALC;
            ST_CALC:   if (cnt_q == CNT_LAST) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        Busy       = (state_q == ST_CALC) || (state_q == ST_FINISH);
        Stall      = Busy && (Start || ReadHiLo || MoveToHi || MoveToLo);
        Done       = done_q;
        ReadDataHi = hi_q;
        ReadDataLo = lo_q;
    end

    // Operand capture: magnitudes feed the unsigned core, signs are fixed up at FINISH.
    always_comb begin
        sgn_in   = is_signed_op(op_in);
        div_in   = is_div_op(op_in);
        neg_a_in = sgn_in && OperandA[WIDTH-1];
        neg_b_in = sgn_in && OperandB[WIDTH-1];
        abs_a    = neg_a_in ? -OperandA : OperandA;
        abs_b    = neg_b_in ? -OperandB : OperandB;
    end

    // Sign correction, accumulation and divide special cases.
    always_comb begin
        prod_mag = {acc_hi_q, acc_lo_q};
        prod_s   = neg_res_q ? -prod_mag : prod_mag;
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod_s;
            OP_MSUB:           mul_res = {hi_q, lo_q} - prod_s;
            default:           mul_res = prod_s;
        endcase
        quot = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem  = neg_a_q ? -acc_hi_q : acc_hi_q;
        if (!is_div_q) begin
            fin_hi = mul_res[2*WIDTH-1:WIDTH];
            fin_lo = mul_res[WIDTH-1:0];
        end else if (div0_q) begin
            fin_hi = a_q;
            fin_lo = DIV0_LO[WIDTH-1:0];
        end else begin
            fin_hi = rem;
            fin_lo = quot;
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        m_d       = m_q;
        a_d       = a_q;
        op_d      = op_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        done_d    = (state_q == ST_FINISH);
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    op_d      = op_in;
                    a_d       = OperandA;
                    is_div_d  = div_in;
                    div0_d    = div_in && (OperandB == '0);
                    neg_res_d = neg_a_in ^ neg_b_in;
                    neg_a_d   = neg_a_in;
                    acc_hi_d  = '0;
                    acc_lo_d  = div_in ? abs_a : abs_b;
                    m_d       = div_in ? abs_b : abs_a;
                    cnt_d     = '0;
                end else if (!Start) begin
                    if (MoveToHi) hi_d = OperandA;
                    if (MoveToLo) lo_d = OperandA;
                end
            end
            ST_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
            end
            ST_FINISH: begin
                hi_d  = fin_hi;
                lo_d  = fin_lo;
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            m_q       <= '0;
            a_q       <= '0;
            op_q      <= OP_NOP;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            m_q       <= m_d;
            a_q       <= a_d;
            op_q      <= op_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// Scoreboard bench for hi_lo_unit: issued ops push reference {HI,LO};
// a monitor pops and compares whenever Done pulses.
module tb_hi_lo_unit;

    logic        Clk = 1'b0;
    logic        Rst, Start, MoveToHi, MoveToLo, ReadHiLo;
    logic [2:0]  HiLoOp;
    logic [31:0] OperandA, OperandB;
    logic [31:0] ReadDataHi, ReadDataLo;
    logic        Busy, Done, Stall;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] mon_exp;

    hi_lo_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .HiLoOp     (HiLoOp),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .MoveToHi   (MoveToHi),
        .MoveToLo   (MoveToLo),
        .ReadHiLo   (ReadHiLo),
        .ReadDataHi (ReadDataHi),
        .ReadDataLo (ReadDataLo),
        .Busy       (Busy),
        .Done       (Done),
        .Stall      (Stall)
    );

    always #5 Clk = ~Clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb, q, r;
        logic [63:0] sp, up, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = 64'(sa * sb);
        up = {32'd0, a} * {32'd0, b};
        q  = 0;
        r  = 0;
        case (op)
            3'd1: res = sp;
            3'd2: res = up;
            3'd5: res = hl + sp;
            3'd6: res = hl + up;
            3'd7: res = hl - sp;
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == 3'd3) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = hl;
        endcase
        return res;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=%h%h expected=none", ReadDataHi, ReadDataLo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("hilo_result", {ReadDataHi, ReadDataLo}, mon_exp);
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int rd_at);
        logic [63:0] old, exp;
        int          n, busy_cnt, done_at;
        logic        hold_bad, stall_bad;
        @(negedge Clk);
        old = {model_hi, model_lo};
        exp = ref_op(op, a, b, old);
        exp_q.push_back(exp);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        Start    = 1'b1;
        HiLoOp   = op;
        OperandA = a;
        OperandB = b;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        HiLoOp   = 3'($urandom);
        OperandA = $urandom;
        OperandB = $urandom;
        n = 0; busy_cnt = 0; done_at = 0; hold_bad = 1'b0; stall_bad = 1'b0;
        while (done_at == 0 && n < 60) begin
            @(negedge Clk);
            n++;
            if (rd_at != 0 && n >= rd_at) ReadHiLo = 1'b1;
            #1;
            if (Busy === 1'b1) begin
                busy_cnt++;
                if ({ReadDataHi, ReadDataLo} !== old) hold_bad = 1'b1;
                if (rd_at != 0 && n >= rd_at && Stall !== 1'b1) stall_bad = 1'b1;
            end
            if (Done === 1'b1) begin
                done_at = n;
                if (rd_at != 0 && Stall !== 1'b0) stall_bad = 1'b1;
            end
        end
        ReadHiLo = 1'b0;
        check("latency", 64'(done_at), 64'd34);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("hold_old", 64'(hold_bad), 64'd0);
        if (rd_at != 0) check("stall", 64'(stall_bad), 64'd0);
        @(negedge Clk);
        #1;
        check("done_pulse", 64'(Done), 64'd0);
    endtask

    task automatic do_move(input logic h, input logic l, input logic [31:0] v);
        @(negedge Clk);
        MoveToHi = h;
        MoveToLo = l;
        OperandA = v;
        @(posedge Clk);
        #1;
        MoveToHi = 1'b0;
        MoveToLo = 1'b0;
        if (h) model_hi = v;
        if (l) model_lo = v;
        check("move", {ReadDataHi, ReadDataLo}, {model_hi, model_lo});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rrd, guard;
        Rst = 1'b1; Start = 1'b0; MoveToHi = 1'b0; MoveToLo = 1'b0; ReadHiLo = 1'b0;
        HiLoOp = 3'd0; OperandA = '0; OperandB = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_hilo", {ReadDataHi, ReadDataLo}, 64'd0);
        check("reset_ctrl", {61'd0, Busy, Done, Stall}, 64'd0);
        Rst = 1'b0;

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_const", {ReadDataHi, ReadDataLo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(3'd5, 32'd2, 32'd3, 0);
        run_op(3'd7, 32'd1, 32'd1, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd4, 32'd7, 32'd2, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h0000_1234, 32'd0, 0);
        run_op(3'd3, 32'h8765_4321, 32'd0, 0);
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        do_move(1'b0, 1'b1, 32'h0000_00AA);
        do_move(1'b1, 1'b1, 32'h5A5A_A5A5);
        do_move(1'b1, 1'b0, 32'h0000_0011);

        // Abort a divide mid-flight with reset.
        @(negedge Clk);
        Start = 1'b1; HiLoOp = 3'd3; OperandA = $urandom; OperandB = 32'd7;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_hilo", {ReadDataHi, ReadDataLo}, 64'd0);
        check("abort_ctrl", {62'd0, Busy, Done}, 64'd0);
        Rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        run_op(3'd2, 32'd2, 32'd3, 0);

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(1, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb & 32'h0000_00FF;
            rrd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
            run_op(rop, ra, rb, rrd);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
